konark_tohost_mailbox: RTL and testbench

KONARK_TOHOST_MAILBOX -- requirements
Module: konark_tohost_mailbox

---
 rtl/konark_tohost_pkg.sv | 34 +++
 rtl/konark_tohost_mailbox.sv | 177 +++++++++++++++++
 tb/tb_konark_tohost_mailbox.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/konark_tohost_pkg.sv
`default_nettype none
// ============================================================================
// Module      : konark_tohost_pkg
// Description : Shared types and helpers for the tohost/fromhost mailbox.
//               Holds the mailbox state enum, the default register byte
//               addresses and the byte-lane write-merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package konark_tohost_pkg;

    // Mailbox protocol state.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PENDING   = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_EXITED    = 2'd3
    } tohost_state_e;

    // Default byte addresses of the two mailbox registers.
    localparam logic [47:0] c_tohost_addr_default   = 48'h0000_8000_1000;
    localparam logic [47:0] c_fromhost_addr_default = 48'h0000_8000_1040;

    // Byte-lane merge: take the new byte when its strobe is set, otherwise
    // keep the old byte. Applied per lane so it works for any data width.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage : konark_tohost_pkg
`default_nettype wire

// File: rtl/konark_tohost_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : konark_tohost_mailbox
// Description : Core-to-host mailbox. The core writes a command word into
//               tohost; the host pops it and either treats it as an exit
//               (bit 0 set, sticky EXITED state) or answers by writing
//               fromhost, which also clears tohost.
// Ports       : clk_i/rst_i          - clock, synchronous active-high reset
//               req_*                - core request channel (valid/ready)
//               rsp_*                - core response, one cycle after accept
//               host_valid_o/ready_i - host pop of the tohost value
//               host_resp_*          - host write into fromhost
//               exit_*/busy_o        - status
// Revision    : 1.0 - initial release
// ============================================================================
module konark_tohost_mailbox
    import konark_tohost_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 48,
    parameter int unsigned          DataWidth    = 64,
    parameter logic [AddrWidth-1:0] TohostAddr   = c_tohost_addr_default,
    parameter logic [AddrWidth-1:0] FromhostAddr = c_fromhost_addr_default
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // core request
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic                   req_write_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    // core response
    output logic                   rsp_valid_o,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_error_o,
    // host pop
    output logic                   host_valid_o,
    input  logic                   host_ready_i,
    output logic [DataWidth-1:0]   host_data_o,
    // host response
    input  logic                   host_resp_valid_i,
    input  logic [DataWidth-1:0]   host_resp_data_i,
    // status
    output logic                   exit_valid_o,
    output logic [30:0]            exit_code_o,
    output logic                   busy_o
);

    localparam int unsigned c_strb_width = DataWidth / 8;

    tohost_state_e        r_state;
    logic [DataWidth-1:0] r_tohost;
    logic [DataWidth-1:0] r_fromhost;
    logic                 r_rsp_valid;
    logic [DataWidth-1:0] r_rsp_rdata;
    logic                 r_rsp_error;
    logic                 r_host_valid;
    logic                 r_exit_valid;
    logic [30:0]          r_exit_code;
    logic                 r_busy;

    logic [DataWidth-1:0] w_tohost_merged;
    logic [DataWidth-1:0] w_fromhost_merged;
    logic                 w_hit_tohost;
    logic                 w_hit_fromhost;
    logic                 w_tohost_stall;
    logic                 w_accept;
    logic                 w_host_resp;

    for (genvar i = 0; i < c_strb_width; i++) begin : g_merge
        assign w_tohost_merged[8*i +: 8]   = merge_byte(r_tohost[8*i +: 8],
                                                        req_wdata_i[8*i +: 8],
                                                        req_strb_i[i]);
        assign w_fromhost_merged[8*i +: 8] = merge_byte(r_fromhost[8*i +: 8],
                                                        req_wdata_i[8*i +: 8],
                                                        req_strb_i[i]);
    end

    assign w_hit_tohost   = (req_addr_i == TohostAddr);
    assign w_hit_fromhost = (req_addr_i == FromhostAddr);

    // Only a new tohost command can stall: the previous one is still in
    // flight with the host. Reads and all other accesses always proceed.
    assign w_tohost_stall = req_write_i && w_hit_tohost &&
                            ((r_state == ST_PENDING) || (r_state == ST_WAIT_RESP));
    assign req_ready_o    = !w_tohost_stall;
    assign w_accept       = req_valid_i && req_ready_o;

    // The host answer only counts while a response is actually awaited.
    assign w_host_resp    = (r_state == ST_WAIT_RESP) && host_resp_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_tohost     <= '0;
            r_fromhost   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_error  <= 1'b0;
            r_host_valid <= 1'b0;
            r_exit_valid <= 1'b0;
            r_exit_code  <= '0;
            r_busy       <= 1'b0;
        end else begin
            // Response: reads see the register values before this edge.
            r_rsp_valid <= w_accept;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            if (w_accept) begin
                if (w_hit_tohost) begin
                    if (!req_write_i) r_rsp_rdata <= r_tohost;
                end else if (w_hit_fromhost) begin
                    if (!req_write_i) r_rsp_rdata <= r_fromhost;
                end else begin
                    r_rsp_error <= 1'b1;
                end
            end

            // fromhost: the host answer beats a colliding core write.
            if (w_host_resp) begin
                r_fromhost <= host_resp_data_i;
            end else if (w_accept && req_write_i && w_hit_fromhost) begin
                r_fromhost <= w_fromhost_merged;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && req_write_i && w_hit_tohost) begin
                        r_tohost <= w_tohost_merged;
                        if (w_tohost_merged != '0) begin
                            r_state      <= ST_PENDING;
                            r_host_valid <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end
                end
                ST_PENDING: begin
                    if (host_ready_i) begin
                        r_host_valid <= 1'b0;
                        if (r_tohost[0]) begin
                            r_state      <= ST_EXITED;
                            r_exit_valid <= 1'b1;
                            r_exit_code  <= r_tohost[31:1];
                        end else begin
                            r_state <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (host_resp_valid_i) begin
                        r_tohost <= '0;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                // Sticky until reset; tohost writes are silently dropped.
                ST_EXITED: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_error_o  = r_rsp_error;
    assign host_valid_o = r_host_valid;
    assign host_data_o  = r_tohost;
    assign exit_valid_o = r_exit_valid;
    assign exit_code_o  = r_exit_code;
    assign busy_o       = r_busy;

endmodule : konark_tohost_mailbox
`default_nettype wire

// File: tb/tb_konark_tohost_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_konark_tohost_mailbox
// Description : Self-checking bench for konark_tohost_mailbox. A behavioural
//               mailbox model predicts every output each cycle; directed
//               scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_konark_tohost_mailbox;

    localparam logic [47:0] c_to   = 48'h0000_8000_1000;
    localparam logic [47:0] c_from = 48'h0000_8000_1040;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [47:0] req_addr_i = '0;
    logic        req_write_i = 1'b0;
    logic [63:0] req_wdata_i = '0;
    logic [7:0]  req_strb_i = '0;
    logic        rsp_valid_o;
    logic [63:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        host_valid_o;
    logic        host_ready_i = 1'b0;
    logic [63:0] host_data_o;
    logic        host_resp_valid_i = 1'b0;
    logic [63:0] host_resp_data_i = '0;
    logic        exit_valid_o;
    logic [30:0] exit_code_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk_i = ~clk_i;

    konark_tohost_mailbox dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .req_write_i       (req_write_i),
        .req_wdata_i       (req_wdata_i),
        .req_strb_i        (req_strb_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_rdata_o       (rsp_rdata_o),
        .rsp_error_o       (rsp_error_o),
        .host_valid_o      (host_valid_o),
        .host_ready_i      (host_ready_i),
        .host_data_o       (host_data_o),
        .host_resp_valid_i (host_resp_valid_i),
        .host_resp_data_i  (host_resp_data_i),
        .exit_valid_o      (exit_valid_o),
        .exit_code_o       (exit_code_o),
        .busy_o            (busy_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 command waiting for host, 2 awaiting host answer, 3 exited
    int          m_phase = 0;
    logic [63:0] m_to    = '0;
    logic [63:0] m_from  = '0;
    bit          m_rv    = 1'b0;
    bit          m_re    = 1'b0;
    logic [63:0] m_rd    = '0;

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] strb);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic bit model_ready();
        return !(req_write_i && req_addr_i == c_to && (m_phase == 1 || m_phase == 2));
    endfunction

    always @(posedge clk_i) begin
        int          nphase;
        logic [63:0] nto;
        logic [63:0] nfrom;
        bit          acc;
        if (rst_i) begin
            m_phase = 0; m_to = '0; m_from = '0; m_rv = 0; m_re = 0; m_rd = '0;
        end else begin
            acc    = req_valid_i && model_ready();
            nphase = m_phase; nto = m_to; nfrom = m_from;
            m_rv = acc; m_re = 0; m_rd = '0;
            if (acc) begin
                if (req_addr_i == c_to) begin
                    if (!req_write_i) m_rd = m_to;
                    else if (m_phase == 0) begin
                        nto = merge(m_to, req_wdata_i, req_strb_i);
                        if (nto != 0) nphase = 1;
                    end
                end else if (req_addr_i == c_from) begin
                    if (!req_write_i) m_rd = m_from;
                    else nfrom = merge(m_from, req_wdata_i, req_strb_i);
                end else begin
                    m_re = 1;
                end
            end
            if (m_phase == 1 && host_ready_i) nphase = m_to[0] ? 3 : 2;
            if (m_phase == 2 && host_resp_valid_i) begin
                nfrom = host_resp_data_i; nto = '0; nphase = 0;
            end
            m_phase = nphase; m_to = nto; m_from = nfrom;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("m_rsp_valid",  rsp_valid_o,  m_rv);
            chk("m_rsp_rdata",  rsp_rdata_o,  m_rd);
            chk("m_rsp_error",  rsp_error_o,  m_re);
            chk("m_req_ready",  req_ready_o,  model_ready());
            chk("m_host_valid", host_valid_o, m_phase == 1);
            chk("m_host_data",  host_data_o,  m_to);
            chk("m_exit_valid", exit_valid_o, m_phase == 3);
            chk("m_exit_code",  exit_code_o,  (m_phase == 3) ? m_to[31:1] : 31'd0);
            chk("m_busy",       busy_o,       m_phase != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [47:0] a, input logic [63:0] d,
                          input logic [7:0] s);
        bit ok;
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a; req_wdata_i = d; req_strb_i = s;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (req_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; req_write_i = 1'b0;
        chk("req_accept_timeout", ok, 1'b1);
    endtask

    task automatic do_pop(input logic [63:0] exp_data);
        bit ok;
        host_ready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (host_valid_o) begin ok = 1'b1; break; end
        end
        chk("pop_timeout", ok, 1'b1);
        chk("pop_host_data", host_data_o, exp_data);
        @(posedge clk_i); #1;
        host_ready_i = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk_en = 1'b1;
        rst_i  = 1'b0;
        chk("reset_rsp_valid",  rsp_valid_o,  0);
        chk("reset_host_valid", host_valid_o, 0);
        chk("reset_exit_valid", exit_valid_o, 0);
        chk("reset_busy",       busy_o,       0);
        chk("reset_req_ready",  req_ready_o,  1);

        // Exit with code 0.
        do_req(1, c_to, 64'h1, 8'hFF);
        chk("t1_rsp_error", rsp_error_o, 0);
        do_pop(64'h1);
        chk("t1_exit_valid", exit_valid_o, 1);
        chk("t1_exit_code",  exit_code_o,  0);
        chk("t1_busy",       busy_o,       1);
        do_reset();

        // Exit with code 10; later tohost writes are ignored.
        do_req(1, c_to, 64'h15, 8'hFF);
        do_pop(64'h15);
        chk("t2_exit_code", exit_code_o, 31'd10);
        do_req(1, c_to, 64'h99, 8'hFF);
        chk("t2_late_rsp_valid", rsp_valid_o, 1);
        chk("t2_late_rsp_error", rsp_error_o, 0);
        do_req(0, c_to, '0, '0);
        chk("t2_tohost_kept", rsp_rdata_o, 64'h15);
        chk("t2_exit_code_held", exit_code_o, 31'd10);
        do_reset();

        // Strobed write: only byte 0 lands.
        do_req(1, c_to, 64'hFFFF_FFFF_FFFF_FF03, 8'h01);
        do_req(0, c_to, '0, '0);
        chk("t3_merged", rsp_rdata_o, 64'h3);
        do_pop(64'h3);
        chk("t3_exit_code", exit_code_o, 31'd1);
        do_reset();

        // Syscall: pop, stalled second write, host answer releases it.
        do_req(1, c_to, 64'h8000_2000, 8'hFF);
        chk("t4_pending", host_valid_o, 1);
        do_pop(64'h8000_2000);
        chk("t4_wait_host_valid", host_valid_o, 0);
        chk("t4_wait_busy", busy_o, 1);
        req_valid_i = 1; req_write_i = 1; req_addr_i = c_to; req_wdata_i = 64'h42; req_strb_i = 8'hFF;
        host_resp_valid_i = 1; host_resp_data_i = 64'h1;
        @(negedge clk_i);
        chk("t4_stall_ready", req_ready_o, 0);
        @(posedge clk_i); #1;
        host_resp_valid_i = 0;
        chk("t4_idle_busy", busy_o, 0);
        chk("t4_tohost_cleared", host_data_o, 64'h0);
        @(negedge clk_i);
        chk("t4_released_ready", req_ready_o, 1);
        @(posedge clk_i); #1;
        req_valid_i = 0; req_write_i = 0;
        chk("t4_released_rsp", rsp_valid_o, 1);
        do_req(0, c_from, '0, '0);
        chk("t4_fromhost", rsp_rdata_o, 64'h1);
        do_req(0, c_to, '0, '0);
        chk("t4_new_tohost", rsp_rdata_o, 64'h42);

        // Host answer collides with a core fromhost write: host wins.
        do_pop(64'h42);
        req_valid_i = 1; req_write_i = 1; req_addr_i = c_from; req_wdata_i = 64'h5; req_strb_i = 8'hFF;
        host_resp_valid_i = 1; host_resp_data_i = 64'h77;
        @(posedge clk_i); #1;
        req_valid_i = 0; req_write_i = 0; host_resp_valid_i = 0;
        chk("t5_collide_rsp", rsp_valid_o, 1);
        chk("t5_collide_err", rsp_error_o, 0);
        do_req(0, c_from, '0, '0);
        chk("t5_host_wins", rsp_rdata_o, 64'h77);

        // Unmapped accesses, clearing fromhost, ignored host answers, zero write.
        do_req(0, 48'h0, '0, '0);
        chk("t6_bad_rd_err",   rsp_error_o, 1);
        chk("t6_bad_rd_rdata", rsp_rdata_o, 0);
        do_req(1, 48'h10, 64'hDEAD, 8'hFF);
        chk("t6_bad_wr_err", rsp_error_o, 1);
        do_req(1, c_from, 64'h0, 8'hFF);
        host_resp_valid_i = 1; host_resp_data_i = 64'hAB;
        @(posedge clk_i); #1;
        host_resp_valid_i = 0;
        do_req(0, c_from, '0, '0);
        chk("t6_fromhost_cleared", rsp_rdata_o, 0);
        do_req(1, c_to, 64'h0, 8'hFF);
        chk("t6_zero_write_idle", busy_o, 0);

        // Reset while awaiting the host answer, with a read in flight.
        do_req(1, c_to, 64'h100, 8'hFF);
        do_pop(64'h100);
        rst_i = 1; req_valid_i = 1; req_write_i = 0; req_addr_i = c_to;
        @(posedge clk_i); #1;
        rst_i = 0; req_valid_i = 0;
        chk("t7_rst_rsp_valid",  rsp_valid_o,  0);
        chk("t7_rst_rsp_rdata",  rsp_rdata_o,  0);
        chk("t7_rst_host_valid", host_valid_o, 0);
        chk("t7_rst_busy",       busy_o,       0);
        chk("t7_rst_host_data",  host_data_o,  0);
        do_req(1, c_to, 64'h200, 8'hFF);
        chk("t7_new_rsp", rsp_valid_o, 1);
        chk("t7_new_busy", busy_o, 1);

        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_konark_tohost_mailbox
`default_nettype wire
